// File: rtl/session_fault_comparator_pkg.sv
// Shared types and sizing helpers for the session-based BIST column comparator.
package session_fault_comparator_pkg;

    // Session controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default per-column mismatch counter width and its saturation value.
    localparam int unsigned DEF_CNT_WIDTH = 4;
    localparam int unsigned CNT_MAX       = (1 << DEF_CNT_WIDTH) - 1;

    // Width of one column partial sum: product width plus accumulation growth.
    function automatic int unsigned psum_width(input int unsigned weight_w,
                                               input int unsigned act_w,
                                               input int unsigned size);
        return weight_w + act_w + $clog2(size);
    endfunction

    // Saturation value of a counter of the given width.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/session_fault_comparator_col_fault_tracker.sv
// Per-column fault tracker: mask bit, registered compare bit, sticky fault bit
// and saturating mismatch counter, driven by clear/update strobes.
module col_fault_tracker
    import session_fault_comparator_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = 19,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_mask,
    input  logic                  i_update,
    input  logic [PSUM_WIDTH-1:0] i_golden,
    input  logic [PSUM_WIDTH-1:0] i_psum,
    output logic                  o_cmp,
    output logic                  o_fault,
    output logic [CNT_WIDTH-1:0]  o_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    logic                 r_mask;
    logic                 r_cmp;
    logic                 r_fault;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_cmp;

    // Exact full-width match; a masked column never reports a mismatch.
    always_comb begin
        w_cmp = (i_golden != i_psum) && !r_mask;
    end

    // Session clear latches the mask; each accepted beat updates compare, sticky bit and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask  <= 1'b0;
            r_cmp   <= 1'b0;
            r_fault <= 1'b0;
            r_count <= '0;
        end else if (i_clear) begin
            r_mask  <= i_mask;
            r_fault <= 1'b0;
            r_count <= '0;
        end else if (i_update) begin
            r_cmp   <= w_cmp;
            r_fault <= r_fault | w_cmp;
            if (w_cmp && (r_count != CNT_FULL)) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_cmp   = r_cmp;
    assign o_fault = r_fault;
    assign o_count = r_count;

endmodule

// File: rtl/session_fault_comparator.sv
// Session-based column comparator for the systolic-array BIST result path.
// Compares every column partial sum against a golden value per accepted beat
// and accumulates a sticky fault map plus saturating per-column counts.
module session_fault_comparator
    import session_fault_comparator_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE     = 8,
    parameter int unsigned WEIGHT_WIDTH      = 8,
    parameter int unsigned ACTIVATION_WIDTH  = 8,
    parameter int unsigned PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
    parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH,
    parameter int unsigned PATTERN_CNT_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [PATTERN_CNT_WIDTH-1:0]           num_patterns,
    input  logic [SYSTOLIC_SIZE-1:0]               col_mask,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [PARTIAL_SUM_WIDTH-1:0]           correct_answer,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] partial_sum_flat,
    output logic [SYSTOLIC_SIZE-1:0]               compared_results,
    output logic                                   result_valid,
    output logic [SYSTOLIC_SIZE-1:0]               fault_map,
    output logic [CNT_WIDTH*SYSTOLIC_SIZE-1:0]     fault_count_flat,
    output logic                                   any_fault,
    output logic                                   busy,
    output logic                                   done
);

    state_t                         r_state;
    logic [PATTERN_CNT_WIDTH-1:0]   r_num;
    logic [PATTERN_CNT_WIDTH-1:0]   r_pat_cnt;
    logic                           r_ready;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_rvalid;

    logic                           w_clear;
    logic                           w_accept;
    logic [PATTERN_CNT_WIDTH-1:0]   w_pat_next;
    logic [SYSTOLIC_SIZE-1:0]       w_cmp;
    logic [SYSTOLIC_SIZE-1:0]       w_fault;

    // Strobes: session clear on a start seen in IDLE, beat acceptance in RUN.
    always_comb begin
        w_clear    = (r_state == IDLE) && start;
        w_accept   = r_ready && in_valid;
        w_pat_next = r_pat_cnt + PATTERN_CNT_WIDTH'(1);
    end

    // Session FSM with registered handshake/status outputs; the last beat's
    // compare lands on the same edge as the move to DONE, so result_valid and done coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_num     <= '0;
            r_pat_cnt <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rvalid <= w_accept;
            r_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num     <= num_patterns;
                        r_pat_cnt <= '0;
                        if (num_patterns != '0) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_pat_cnt <= w_pat_next;
                        if (w_pat_next == r_num) begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < SYSTOLIC_SIZE; gi++) begin : g_col
        col_fault_tracker #(
            .PSUM_WIDTH (PARTIAL_SUM_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_trk (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (w_clear),
            .i_mask   (col_mask[gi]),
            .i_update (w_accept),
            .i_golden (correct_answer),
            .i_psum   (partial_sum_flat[gi*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH]),
            .o_cmp    (w_cmp[gi]),
            .o_fault  (w_fault[gi]),
            .o_count  (fault_count_flat[gi*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign in_ready         = r_ready;
    assign busy             = r_busy;
    assign done             = r_done;
    assign result_valid     = r_rvalid;
    assign compared_results = w_cmp;
    assign fault_map        = w_fault;
    assign any_fault        = |w_fault;

endmodule
